// File: rtl/rf_pkg.sv
// Shared register-file types and sizes, used by the register file, its read mux
// and the read-port arbiter.
package rf_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr,
// searching upward and wrapping from N_REQ-1 to 0.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    int          k;
    logic [ID_W-1:0] kk;
    // NOTE: every variable written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    grant = '0;
    idx   = '0;
    k     = 0;
    kk    = '0;
    // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      kk = ID_W'(k);
      if (req[kk]) begin
        grant     = '0;
        grant[kk] = 1'b1;
        idx       = kk;
      end
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin sharing of the register-file read port with a one-entry tagged response buffer.
// Optional build macro: RF_ARB_ZERO_BYPASS_EN (address 0 returns zero without using the mux).
module rf_read_arbiter
  import rf_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int ADDR_W = RF_ADDR_W,
  parameter  int DATA_W = RF_DATA_W,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [ADDR_W-1:0]       rf_raddr_o,
  input  logic [DATA_W-1:0]       rf_rdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic [ID_W-1:0]         rsp_id_o
);

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   ptr_next;
  logic              slot_free;
  logic [N_REQ-1:0]  req_elig;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] data_next;

  // Requests are hidden from the arbiter while the buffer cannot take a new entry or reset is held.
  assign slot_free = !rsp_valid_o || rsp_ready_i;
  assign req_elig  = (slot_free && rst_n_i) ? req_valid_i : '0;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req_elig),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign gnt_any     = |grant;
  assign gnt_addr    = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
  assign req_ready_o = grant;
  assign ptr_next    = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

`ifdef RF_ARB_ZERO_BYPASS_EN
  logic zero_hit;
  assign zero_hit   = gnt_any && (gnt_addr == '0);
  assign rf_raddr_o = (gnt_any && !zero_hit) ? gnt_addr : '0;
  assign data_next  = zero_hit ? '0 : rf_rdata_i;
`else
  assign rf_raddr_o = gnt_any ? gnt_addr : '0;
  assign data_next  = rf_rdata_i;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order. The data buffer is reset
  // too, so the response outputs read as defined zeros out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
      rr_ptr      <= '0;
    end else if (gnt_any) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= data_next;
      rsp_id_o    <= gnt_idx;
      rr_ptr      <= ptr_next;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Scoreboard bench for rf_read_arbiter: grants checked per cycle, responses
// popped from an expected-response queue when the consumer takes them.
module tb_rf_read_arbiter;
  import rf_pkg::*;

  localparam int N  = 4;
  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;
  localparam int IW = 2;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [N-1:0]    req_valid_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N-1:0]    req_ready_o;
  rf_addr_t        rf_raddr_o;
  rf_data_t        rf_rdata_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  rf_data_t        rsp_data_o;
  logic [IW-1:0]   rsp_id_o;

  always #5 clk_i = ~clk_i;

  rf_read_arbiter #(.N_REQ(N)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_ready_o (req_ready_o),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o)
  );

  // Register-file contents and combinational read mux model.
  rf_data_t regs [RF_NUM_REGS];
  assign rf_rdata_i = regs[rf_raddr_o];

  typedef struct packed {
    logic [IW-1:0] id;
    rf_data_t      data;
  } rsp_t;

  rsp_t sb[$];
  rsp_t exp_rsp;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_ptr = 0;
  logic m_rsp_valid = 1'b0;

  function automatic rf_data_t exp_data(input rf_addr_t a);
`ifdef RF_ARB_ZERO_BYPASS_EN
    if (a == '0) return '0;
`endif
    return regs[a];
  endfunction

  function automatic rf_addr_t addr_of(input int k);
    return req_addr_i[k*AW +: AW];
  endfunction

  // Expected winner this cycle from the bench's own arbitration state, -1 for none.
  function automatic int model_grant();
    if (!rst_n_i) return -1;
    if (m_rsp_valid && !rsp_ready_i) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_valid_i[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_addr(input int k, input rf_addr_t a);
    req_addr_i[k*AW +: AW] = a;
  endtask

  // One clock cycle: sample grant side mid-cycle, push the expected response, update the model.
  task automatic tick(output logic [N-1:0] got_ready, output rf_addr_t got_raddr);
    int g;
    @(negedge clk_i);
    g         = model_grant();
    got_ready = req_ready_o;
    got_raddr = rf_raddr_o;
    if (g >= 0) sb.push_back('{id: IW'(g), data: exp_data(addr_of(g))});
    @(posedge clk_i);
    if (g >= 0) begin
      m_ptr       = (g + 1) % N;
      m_rsp_valid = 1'b1;
    end else if (rsp_ready_i) begin
      m_rsp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    sb.delete();
    m_ptr       = 0;
    m_rsp_valid = 1'b0;
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  // Response monitor: compares every consumed response with the queue head.
  always @(negedge clk_i) begin
    if (rst_n_i && rsp_valid_o && rsp_ready_i) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h, wanted no response", rsp_id_o, rsp_data_o);
      end else begin
        exp_rsp = sb.pop_front();
        if (rsp_id_o !== exp_rsp.id || rsp_data_o !== exp_rsp.data) begin
          n_bad++;
          $display("FAIL rsp_data: got id=%0d data=%h, wanted id=%0d data=%h",
                   rsp_id_o, rsp_data_o, exp_rsp.id, exp_rsp.data);
        end
      end
    end
  end

  task automatic test_reset();
    logic [N-1:0] r;
    rf_addr_t     a;
    req_valid_i = 4'b1111;
    rsp_ready_i = 1'b1;
    rst_n_i     = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    n_cmp++;
    if (req_ready_o !== '0 || rsp_valid_o !== 1'b0 || rsp_data_o !== '0 ||
        rsp_id_o !== '0 || rf_raddr_o !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got ready=%b valid=%b data=%h id=%0d raddr=%0d, wanted all zero",
               req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, rf_raddr_o);
    end
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    tick(r, a);
    n_cmp++;
    if (r !== 4'b0001 || a !== addr_of(0)) begin
      n_bad++;
      $display("FAIL reset_first_grant: got ready=%b raddr=%0d, wanted ready=0001 raddr=%0d", r, a, addr_of(0));
    end
    req_valid_i = '0;
    tick(r, a);
  endtask

  task automatic test_single();
    logic [N-1:0] r;
    rf_addr_t     a;
    req_valid_i = 4'b0100;
    set_addr(2, 5'd5);
    rsp_ready_i = 1'b1;
    tick(r, a);
    n_cmp++;
    if (r !== 4'b0100 || a !== 5'd5) begin
      n_bad++;
      $display("FAIL single_grant: got ready=%b raddr=%0d, wanted ready=0100 raddr=5", r, a);
    end
    req_valid_i = '0;
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hDEADBEEF || rsp_id_o !== 2'd2) begin
      n_bad++;
      $display("FAIL single_rsp: got valid=%b data=%h id=%0d, wanted 1 deadbeef 2", rsp_valid_o, rsp_data_o, rsp_id_o);
    end
    tick(r, a);
  endtask

  task automatic test_all_rr();
    logic [N-1:0] r;
    rf_addr_t     a;
    int           seq [6];
    seq = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int k = 0; k < N; k++) set_addr(k, AW'(k + 8));
    req_valid_i = 4'b1111;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(r, a);
      n_cmp++;
      if (r !== (4'b0001 << seq[i]) || a !== AW'(seq[i] + 8)) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: got ready=%b raddr=%0d, wanted requester %0d", i, r, a, seq[i]);
      end
    end
    req_valid_i = '0;
    tick(r, a);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] r;
    rf_addr_t     a;
    set_addr(0, 5'd7);
    set_addr(1, 5'd9);
    req_valid_i = 4'b0001;
    rsp_ready_i = 1'b0;
    tick(r, a);
    req_valid_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick(r, a);
      n_cmp++;
      if (r !== '0 || rsp_valid_o !== 1'b1 || rsp_data_o !== regs[7] || rsp_id_o !== 2'd0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b data=%h id=%0d, wanted 0000 1 %h 0",
                 i, r, rsp_valid_o, rsp_data_o, rsp_id_o, regs[7]);
      end
    end
    rsp_ready_i = 1'b1;
    tick(r, a);
    n_cmp++;
    if (r !== 4'b0010 || a !== 5'd9) begin
      n_bad++;
      $display("FAIL bp_release: got ready=%b raddr=%0d, wanted 0010 raddr=9", r, a);
    end
    req_valid_i = '0;
    tick(r, a);
  endtask

  task automatic test_wrap_and_lone();
    logic [N-1:0] r;
    rf_addr_t     a;
    logic [N-1:0] want [3];
    want = '{4'b1000, 4'b0001, 4'b1000};
    set_addr(0, 5'd31);
    set_addr(2, 5'd3);
    set_addr(3, 5'd17);
    req_valid_i = 4'b0100;
    tick(r, a);
    req_valid_i = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick(r, a);
      n_cmp++;
      if (r !== want[i]) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got ready=%b, wanted %b", i, r, want[i]);
      end
    end
    req_valid_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick(r, a);
      n_cmp++;
      if (r !== 4'b0010) begin
        n_bad++;
        $display("FAIL lone[%0d]: got ready=%b, wanted 0010", i, r);
      end
    end
    req_valid_i = '0;
    tick(r, a);
  endtask

  task automatic test_zero_addr();
    logic [N-1:0] r;
    rf_addr_t     a;
    rf_data_t     want;
`ifdef RF_ARB_ZERO_BYPASS_EN
    want = '0;
`else
    want = 32'h1234;
`endif
    set_addr(0, 5'd0);
    req_valid_i = 4'b0001;
    tick(r, a);
    req_valid_i = '0;
    n_cmp++;
    if (r !== 4'b0001 || a !== 5'd0 || rsp_data_o !== want || rsp_id_o !== 2'd0) begin
      n_bad++;
      $display("FAIL zero_addr: got ready=%b raddr=%0d data=%h id=%0d, wanted 0001 0 %h 0",
               r, a, rsp_data_o, rsp_id_o, want);
    end
    tick(r, a);
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] r;
    rf_addr_t     a;
    req_valid_i = 4'b0100;
    rsp_ready_i = 1'b0;
    tick(r, a);
    req_valid_i = 4'b1111;
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== '0 || rf_raddr_o !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b ready=%b raddr=%0d, wanted 0 0000 0", rsp_valid_o, req_ready_o, rf_raddr_o);
    end
    sb.delete();
    m_ptr       = 0;
    m_rsp_valid = 1'b0;
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    rsp_ready_i = 1'b1;
    tick(r, a);
    n_cmp++;
    if (r !== 4'b0001) begin
      n_bad++;
      $display("FAIL mid_reset_ptr: got ready=%b, wanted 0001", r);
    end
    req_valid_i = '0;
    repeat (2) tick(r, a);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d responses outstanding, wanted 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < RF_NUM_REGS; i++) regs[i] = 32'hA5000000 | (i * 32'h00010101);
    regs[0]     = 32'h1234;
    regs[5]     = 32'hDEADBEEF;
    rst_n_i     = 1'b0;
    req_valid_i = '0;
    req_addr_i  = '0;
    rsp_ready_i = 1'b1;
    for (int k = 0; k < N; k++) set_addr(k, AW'(k + 1));

    test_reset();
    test_single();
    test_all_rr();
    test_backpressure();
    test_wrap_and_lone();
    test_zero_addr();
    test_mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_read_arbiter.md
Name: rf_read_arbiter

Overview:
- Shares the single register-file read port (5-bit selector into the 32x32 read mux) between N_REQ requesters, e.g. fetch/decode, debug and DMA.
- Round-robin arbitration with a valid/ready request handshake.
- Registers the selected 32-bit read data into a one-entry response buffer tagged with the requester ID.
- Sits between the requesters and the register-file read mux; the mux stays purely combinational.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.
- ID_W, $clog2(N_REQ), width of the response tag (derived; not overridden).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  N_REQ  per-requester read request valid.
- req_addr_i  in  N_REQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- req_ready_o  out  N_REQ  one-hot grant; the request is accepted when valid & ready.
- rf_raddr_o  out  ADDR_W  selector driven to the register-file read mux.
- rf_rdata_i  in  DATA_W  mux output; a combinational function of rf_raddr_o in the same cycle.
- rsp_valid_o  out  1  response buffer holds data.
- rsp_ready_i  in  1  response consumer accepts.
- rsp_data_o  out  DATA_W  registered read data.
- rsp_id_o  out  ID_W  index of the requester that owns rsp_data_o.

Behaviour:
- Reset (rst_n_i low, asynchronous) clears: rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rr_ptr=0.
- While rst_n_i is low: req_ready_o=0 and rf_raddr_o=0.
- slot_free = !rsp_valid_o | rsp_ready_i. Grants occur only when slot_free=1.
- Arbitration (combinational):
  - Search req_valid_i starting at rr_ptr, ascending, wrapping at N_REQ-1 to 0.
  - The first valid index g is granted: req_ready_o = 1<<g and rf_raddr_o = req_addr_i[g].
  - If no grant: req_ready_o=0 and rf_raddr_o=0.
- On a grant, at the next edge: rsp_data_o <= rf_rdata_i, rsp_id_o <= g, rsp_valid_o <= 1, rr_ptr <= (g+1) mod N_REQ.
- Latency: request accepted in cycle T, response valid in cycle T+1.
- Throughput: one read per cycle while rsp_ready_i=1.
- No grant and rsp_ready_i=1: rsp_valid_o <= 0. rsp_data_o and rsp_id_o hold their last values.
- Backpressure (rsp_valid_o=1, rsp_ready_i=0):
  - No grants; rsp_* hold; rr_ptr holds.
  - Requesters must keep valid and address stable until ready.
- Simultaneous consume and grant (rsp_valid_o=1, rsp_ready_i=1, a request pending): the buffer is refilled in the same edge with no bubble.
- rr_ptr advances only on a grant. A lone requester is granted every free cycle.
- A requester dropping valid without being granted is legal; it has no effect on state.
- Reset asserted mid-transfer: a pending response is discarded and rr_ptr returns to 0.
- Address 31 and ptr wrap from N_REQ-1 to 0 need no special handling.

Optional Feature:
- Macro: RF_ARB_ZERO_BYPASS_EN
- Defined:
  - A granted read of address 0 loads rsp_data_o <= 0, ignoring rf_rdata_i.
  - rf_raddr_o is driven 0 for that grant.
  - Handshake, latency and rr_ptr update are unchanged.
- Undefined: address 0 is read from the mux like any other register.

Decomposition:
- Shared package rf_pkg:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_NUM_REGS=32.
  - Typedefs rf_addr_t and rf_data_t, reused by the register file, the mux and this block.
- Sub-module rr_arbiter (N_REQ parameter): inputs req and ptr, outputs one-hot grant and encoded index; purely combinational.
- rf_read_arbiter instantiates rr_arbiter and owns rr_ptr and the response buffer.

Test Plan:
- Reset with req_valid_i=4'b1111 and rst_n_i=0 -> req_ready_o=0, rsp_valid_o=0, rsp_data_o=0. After release, the first grant goes to requester 0.
- Preload R5=32'hDEADBEEF; only requester 2 valid with addr 5, rsp_ready_i=1 -> req_ready_o=4'b0100 in cycle T. In T+1: rsp_valid_o=1, rsp_data_o=32'hDEADBEEF, rsp_id_o=2.
- All four requesters valid continuously, rsp_ready_i=1 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id_o follows one cycle later.
- Response held with rsp_ready_i=0 for 3 cycles while requester 1 is valid -> req_ready_o=0 and rsp_* stable for those cycles. On the cycle rsp_ready_i=1, requester 1 is granted with no idle cycle.
- rr_ptr=3, only requesters 0 and 3 valid -> grant 3, then 0, then 3 (wrap-around).
- With RF_ARB_ZERO_BYPASS_EN defined, R0 forced to 32'h1234 in the model, read of addr 0 -> rsp_data_o=0. Without the macro -> rsp_data_o=32'h1234.
